// File: rtl/pattern_writer.sv
// Button-driven frame editor that commits frames to the pattern RAM write port and can zero-fill it.
// Latency: wren 2 cycles after the commit press is first sampled; backpressure: none, the RAM always accepts.
module pattern_writer #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 10
) (
    input  logic              CLK_50,
    input  logic              reset,
    input  logic              btn_next_n,
    input  logic              btn_toggle_n,
    input  logic              btn_commit_n,
    input  logic              btn_clear_n,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wren,
    output logic [DATA_W-1:0] frame,
    output logic [3:0]        cursor,
    output logic [ADDR_W:0]   frame_count,
    output logic              busy
);

    typedef enum logic [1:0] {
        EDIT  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   CNT_MAX    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [3:0]        CURSOR_MAX = 4'(DATA_W - 1);
    localparam logic [DATA_W-1:0] ONE        = DATA_W'(1);

    state_t            state;
    logic [3:0]        btn_hist;
    logic [3:0]        btn_ev;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] sweep_addr;
    logic [3:0]        btn_now;

    // Bit order {clear, commit, toggle, next}; levels are active-low.
    assign btn_now = {btn_clear_n, btn_commit_n, btn_toggle_n, btn_next_n};

    always_ff @(posedge CLK_50 or posedge reset) begin
        if (reset) begin
            state       <= EDIT;
            btn_hist    <= 4'hF;
            btn_ev      <= 4'h0;
            wr_ptr      <= '0;
            sweep_addr  <= '0;
            wr_addr     <= '0;
            wr_data     <= '0;
            wren        <= 1'b0;
            frame       <= '0;
            cursor      <= 4'd0;
            frame_count <= '0;
            busy        <= 1'b0;
        end else begin
            btn_hist <= btn_now;
            // Presses landing inside a sweep are discarded, including on its final cycle.
            btn_ev   <= (state == CLEAR) ? 4'h0 : (btn_hist & ~btn_now);

            case (state)
                EDIT: begin
                    wren <= 1'b0;
                    busy <= 1'b0;
                    if (btn_ev[3]) begin
                        state      <= CLEAR;
                        sweep_addr <= '0;
                    end else if (btn_ev[2]) begin
                        state <= WRITE;
                    end else if (btn_ev[1]) begin
                        frame <= frame ^ (ONE << cursor);
                    end else if (btn_ev[0]) begin
                        cursor <= (cursor == CURSOR_MAX) ? 4'd0 : cursor + 4'd1;
                    end
                end
                WRITE: begin
                    wren    <= 1'b1;
                    wr_addr <= wr_ptr;
                    wr_data <= frame;
                    wr_ptr  <= wr_ptr + 1'b1;
                    if (frame_count != CNT_MAX) begin
                        frame_count <= frame_count + 1'b1;
                    end
                    state <= EDIT;
                end
                CLEAR: begin
                    busy       <= 1'b1;
                    wren       <= 1'b1;
                    wr_addr    <= sweep_addr;
                    wr_data    <= '0;
                    sweep_addr <= sweep_addr + 1'b1;
                    if (&sweep_addr) begin
                        state       <= EDIT;
                        wr_ptr      <= '0;
                        frame_count <= '0;
                        frame       <= '0;
                        cursor      <= 4'd0;
                    end
                end
                default: state <= EDIT;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_writer.sv
// Directed bench for pattern_writer: vector table for editing/commit plus hand sequences for latency, clear and wrap.
module tb_pattern_writer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst_s = 1'b1;
    logic       btn_next_n = 1'b1;
    logic       btn_toggle_n = 1'b1;
    logic       btn_commit_n = 1'b1;
    logic       btn_clear_n = 1'b1;

    logic [9:0] wr_addr;
    logic [9:0] wr_data;
    logic       wren;
    logic [9:0] frame;
    logic [3:0] cursor;
    logic [10:0] frame_count;
    logic       busy;

    logic [1:0] s_wr_addr;
    logic [9:0] s_wr_data;
    logic       s_wren;
    logic [9:0] s_frame;
    logic [3:0] s_cursor;
    logic [2:0] s_frame_count;
    logic       s_busy;

    always #5 clk = ~clk;

    pattern_writer #(.ADDR_W(10), .DATA_W(10)) u_dut (
        .CLK_50(clk), .reset(rst),
        .btn_next_n(btn_next_n), .btn_toggle_n(btn_toggle_n),
        .btn_commit_n(btn_commit_n), .btn_clear_n(btn_clear_n),
        .wr_addr(wr_addr), .wr_data(wr_data), .wren(wren),
        .frame(frame), .cursor(cursor), .frame_count(frame_count), .busy(busy)
    );

    pattern_writer #(.ADDR_W(2), .DATA_W(10)) u_small (
        .CLK_50(clk), .reset(rst_s),
        .btn_next_n(btn_next_n), .btn_toggle_n(btn_toggle_n),
        .btn_commit_n(btn_commit_n), .btn_clear_n(btn_clear_n),
        .wr_addr(s_wr_addr), .wr_data(s_wr_data), .wren(s_wren),
        .frame(s_frame), .cursor(s_cursor), .frame_count(s_frame_count), .busy(s_busy)
    );

    int         errors = 0;
    int         checks = 0;

    // Write monitor, sampled on the falling edge.
    int         wcnt = 0;
    int         clr_cnt = 0;
    logic       sweep_bad = 1'b0;
    logic [9:0] last_addr = '0;
    logic [9:0] last_data = '0;
    logic [1:0] s_addrs[$];

    always @(negedge clk) begin
        if (wren) begin
            wcnt++;
            last_addr = wr_addr;
            last_data = wr_data;
        end
        if (busy) begin
            if (!wren || wr_data != 10'd0 || wr_addr != 10'(clr_cnt % 1024)) sweep_bad = 1'b1;
            clr_cnt++;
        end
        if (s_wren) s_addrs.push_back(s_wr_addr);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // m bits: [0] next, [1] toggle, [2] commit, [3] clear
    task automatic press(input logic [3:0] m, input int hold);
        @(negedge clk);
        btn_next_n   = ~m[0];
        btn_toggle_n = ~m[1];
        btn_commit_n = ~m[2];
        btn_clear_n  = ~m[3];
        repeat (hold) @(negedge clk);
        btn_next_n   = 1'b1;
        btn_toggle_n = 1'b1;
        btn_commit_n = 1'b1;
        btn_clear_n  = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    typedef struct {
        logic [3:0] m;
        logic [9:0] frame;
        logic [3:0] cur;
        int         cnt;
        int         writes;
        logic [9:0] addr;
        logic [9:0] data;
    } vec_t;

    vec_t tbl[17];

    initial begin
        int w0;
        int n;
        logic [1:0] exp_s[5];

        tbl[0]  = '{4'b0010, 10'h001, 4'd0, 0, 0, 10'd0, 10'h000};
        tbl[1]  = '{4'b0001, 10'h001, 4'd1, 0, 0, 10'd0, 10'h000};
        tbl[2]  = '{4'b0001, 10'h001, 4'd2, 0, 0, 10'd0, 10'h000};
        tbl[3]  = '{4'b0010, 10'h005, 4'd2, 0, 0, 10'd0, 10'h000};
        tbl[4]  = '{4'b0100, 10'h005, 4'd2, 1, 1, 10'd0, 10'h005};
        tbl[5]  = '{4'b0100, 10'h005, 4'd2, 2, 2, 10'd1, 10'h005};
        for (int i = 0; i < 8; i++)
            tbl[6+i] = '{4'b0001, 10'h005, 4'((3 + i) % 10), 2, 2, 10'd1, 10'h005};
        tbl[14] = '{4'b0110, 10'h005, 4'd0, 3, 3, 10'd2, 10'h005};
        tbl[15] = '{4'b0010, 10'h004, 4'd0, 3, 3, 10'd2, 10'h005};
        tbl[16] = '{4'b0001, 10'h004, 4'd1, 3, 3, 10'd2, 10'h005};

        // Reset state and idle behaviour
        repeat (3) @(negedge clk);
        check("reset_wren", wren, 0);
        check("reset_busy", busy, 0);
        check("reset_addr", wr_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("idle_writes", wcnt, 0);
        check("idle_frame", frame, 0);
        check("idle_cursor", cursor, 0);
        check("idle_count", frame_count, 0);

        for (int i = 0; i < 17; i++) begin
            press(tbl[i].m, 5);
            check($sformatf("vec%0d_frame", i), frame, tbl[i].frame);
            check($sformatf("vec%0d_cursor", i), cursor, tbl[i].cur);
            check($sformatf("vec%0d_count", i), frame_count, tbl[i].cnt);
            check($sformatf("vec%0d_writes", i), wcnt, tbl[i].writes);
            check($sformatf("vec%0d_addr", i), last_addr, tbl[i].addr);
            check($sformatf("vec%0d_data", i), last_data, tbl[i].data);
        end

        // Commit latency: first sampling edge k, wren visible only after k+2
        @(negedge clk);
        btn_commit_n = 1'b0;
        @(posedge clk); #1;
        check("lat_k0_wren", wren, 0);
        @(posedge clk); #1;
        check("lat_k1_wren", wren, 0);
        @(posedge clk); #1;
        check("lat_k2_wren", wren, 1);
        check("lat_k2_addr", wr_addr, 3);
        check("lat_k2_data", wr_data, 10'h004);
        @(posedge clk); #1;
        check("lat_k3_wren", wren, 0);
        @(negedge clk);
        btn_commit_n = 1'b1;
        repeat (4) @(negedge clk);
        check("lat_count", frame_count, 4);

        // Full clear sweep with a commit pressed in the middle
        w0 = wcnt;
        press(4'b1000, 5);
        repeat (300) @(negedge clk);
        check("clr_busy_mid", busy, 1);
        press(4'b0100, 5);
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("clr_done_in_time", n < 2000, 1);
        check("clr_busy_cycles", clr_cnt, 1024);
        check("clr_sweep_ok", sweep_bad, 0);
        check("clr_writes", wcnt - w0, 1024);
        repeat (10) @(negedge clk);
        check("clr_no_late_write", wcnt - w0, 1024);
        check("clr_count", frame_count, 0);
        check("clr_frame", frame, 0);
        check("clr_cursor", cursor, 0);

        // Asynchronous reset in the middle of a sweep
        press(4'b1000, 5);
        n = 0;
        while (!(busy && wr_addr == 10'd500) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("mid_sweep_reached", n < 2000, 1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("async_wren", wren, 0);
        check("async_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        w0 = wcnt;
        press(4'b0100, 5);
        check("post_rst_writes", wcnt - w0, 1);
        check("post_rst_addr", last_addr, 0);
        check("post_rst_count", frame_count, 1);

        // Long hold produces one write only
        w0 = wcnt;
        press(4'b0100, 200);
        check("hold_writes", wcnt - w0, 1);
        check("hold_addr", last_addr, 1);
        check("hold_count", frame_count, 2);

        // Narrow address space: pointer wrap and count saturation
        @(negedge clk);
        rst_s = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) press(4'b0100, 5);
        exp_s = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        check("wrap_nwrites", s_addrs.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < s_addrs.size()) check($sformatf("wrap_addr%0d", i), s_addrs[i], exp_s[i]);
        check("wrap_count_sat", s_frame_count, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pattern_writer.md
Name: pattern_writer

Overview:
Write-side controller for the dual-clock pattern RAM. The sequencer reads frames from that RAM; this block builds those frames. It takes four debounced, active-low push-button levels and uses them to edit a frame register bit by bit. It commits frames to sequential RAM addresses through the RAM write port (wraddress/data/wren) and can clear the whole RAM. It runs in the CLK_50 domain, which is the RAM write-clock side.

Parameters:
ADDR_W, 10, RAM address width; must match the sequencer read address width.
DATA_W, 10, frame width (one bit per LED); legal range 2..16.

Ports:
CLK_50  input  1  system clock, 50 MHz; all state updates on its rising edge.
reset  input  1  asynchronous, active-high reset.
btn_next_n  input  1  debounced level, active-low; advances the edit cursor.
btn_toggle_n  input  1  debounced level, active-low; inverts frame[cursor].
btn_commit_n  input  1  debounced level, active-low; writes the frame to RAM.
btn_clear_n  input  1  debounced level, active-low; zero-fills the RAM.
wr_addr  output  ADDR_W  RAM write address.
wr_data  output  DATA_W  RAM write data.
wren  output  1  RAM write enable, active-high.
frame  output  DATA_W  frame under edit; drives the LED preview.
cursor  output  4  bit index being edited (0..DATA_W-1); drives a HEX digit.
frame_count  output  ADDR_W+1  number of frames committed since the last clear or reset.
busy  output  1  high while a clear sweep is in progress.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-sweep):
  - Outputs: wr_addr=0, wr_data=0, wren=0, frame=0, cursor=0, frame_count=0, busy=0.
  - Internal: write pointer=0, state=EDIT, button history registers=1 (released).
- Event detection:
  - Each button has a 1-cycle history register.
  - An event pulse is registered when the history is 1 and the current sample is 0.
  - The pulse lasts exactly one cycle per press. A held button produces no further events.
- Priority when events coincide in the same cycle: clear > commit > toggle > next. Lower-priority events in that cycle are dropped.
- State EDIT:
  - next event: cursor+1; DATA_W-1 wraps to 0.
  - toggle event: frame[cursor] inverted.
  - commit event: go to WRITE.
  - clear event: go to CLEAR with sweep address 0.
- State WRITE (one cycle), then back to EDIT:
  - Outputs: wren=1, wr_addr=pointer, wr_data=frame.
  - Following cycle: pointer+1, wrapping from 2^ADDR_W-1 to 0.
  - frame_count+1, saturating at 2^ADDR_W.
  - frame and cursor unchanged, so the user can edit incrementally.
- Latency: wren rises exactly 2 CLK_50 cycles after the first clock edge that samples the commit button low.
- State CLEAR:
  - busy=1; wren=1 on every cycle; wr_data=0; wr_addr counts 0..2^ADDR_W-1, one address per cycle. That is exactly 2^ADDR_W consecutive write cycles.
  - After the last address: state=EDIT, busy=0, wren=0, pointer=0, frame_count=0, frame=0, cursor=0.
  - All button events during CLEAR are ignored, and history registers keep tracking the inputs. A button already held when CLEAR ends does not generate an event.
- wren is 0 in EDIT. wr_addr/wr_data hold their last driven values when wren=0.
- Pointer wrap: after 2^ADDR_W commits, the next commit overwrites address 0. frame_count stays at 2^ADDR_W.
- All outputs are registered; none are combinational from the inputs.

Test Plan:
- Reset released, no presses -> wren stays 0 for 100 cycles; frame=0, cursor=0, frame_count=0.
- Press toggle, next, next, toggle (each 5 cycles low) -> frame=10'b0000000101, cursor=2.
- Then commit -> a single 1-cycle wren with wr_addr=0 and wr_data=10'h005, 2 cycles after first low sample; frame_count=1. A second commit writes wr_addr=1.
- Ten next presses from cursor=0 with DATA_W=10 -> cursor returns to 0. Toggle and commit in the same cycle -> one write of the unmodified frame; frame unchanged.
- Clear press with frame_count=3 -> busy high for exactly 1024 cycles; wren high throughout; wr_addr sweeps 0..1023 with data 0; then frame_count=0. A commit pressed mid-sweep is ignored.
- Assert reset at sweep address 500 -> wren and busy drop in the same cycle (asynchronous). After release, the next commit writes wr_addr=0.
- Hold commit for 200 cycles -> exactly one write.
- With ADDR_W=2, five commits -> addresses 0,1,2,3,0; frame_count saturates at 4.
